// File: rtl/cfu_packed_mac.sv
// Packed signed dot-product CFU with a persistent accumulator, requantisation
// and four free-running performance counters driven by the core's retire strobe.
module cfu_packed_mac #(
    parameter int WIDTH     = 32,
    parameter int LANE_W    = 4,
    parameter int SHIFT     = 5,
    parameter int LOAD_LAT  = 46,
    parameter int STORE_LAT = 47
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_cfu_rs1,
    input  logic [WIDTH-1:0] i_cfu_rs2,
    input  logic [2:0]       i_cfu_op,
    input  logic             i_cfu_valid,
    input  logic             i_ibus_ack,
    input  logic             i_rf_rreq,
    input  logic [31:0]      i_instruction,
    output logic             o_cfu_ready,
    output logic [WIDTH-1:0] o_cfu_rd
);

    localparam int N     = WIDTH / LANE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_DOT        = 3'b000;
    localparam logic [2:0] OP_DOTACC     = 3'b001;
    localparam logic [2:0] OP_QUANT      = 3'b010;
    localparam logic [2:0] OP_QUANT_RELU = 3'b011;
    localparam logic [2:0] OP_ACC_RDCLR  = 3'b100;
    localparam logic [2:0] OP_CNT_RD     = 3'b101;
    localparam logic [2:0] OP_CNT_CLR    = 3'b110;
    localparam logic [2:0] OP_ACC_SET    = 3'b111;

    // Clamp bounds of a signed LANE_W-bit value; ~QMAX equals -QMAX-1.
    localparam logic signed [WIDTH-1:0] QMAX = WIDTH'((2 ** (LANE_W - 1)) - 1);
    localparam logic signed [WIDTH-1:0] QMIN = ~QMAX;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] rs1_q, rs1_d;
    logic [WIDTH-1:0] rs2_q, rs2_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] cnt_cyc_q, cnt_cyc_d;
    logic [WIDTH-1:0] cnt_tot_q, cnt_tot_d;
    logic [WIDTH-1:0] cnt_cpu_q, cnt_cpu_d;
    logic [WIDTH-1:0] cnt_ls_q, cnt_ls_d;

    logic signed [LANE_W-1:0]   a_lane_s, b_lane_s;
    logic signed [2*LANE_W-1:0] prod_s;
    logic [WIDTH-1:0]           prod_ext_s;
    logic [WIDTH-1:0]           psum_next_s;
    logic [WIDTH-1:0]           sum_s;
    logic signed [WIDTH-1:0]    shr_s;
    logic [WIDTH-1:0]           quant_s;
    logic [WIDTH-1:0]           cnt_sel_s;
    logic                       retire_s, is_load_s, is_store_s, is_mul_s;
    logic [WIDTH-1:0]           cyc_inc_s;
    logic                       cnt_clr_s;
    logic                       unused_s;

    assign unused_s = ^{i_instruction[24:7], i_instruction[1:0]};

    // Current lane product, sign-extended to the accumulator width.
    always_comb begin
        a_lane_s    = rs1_q[idx_q * LANE_W +: LANE_W];
        b_lane_s    = rs2_q[idx_q * LANE_W +: LANE_W];
        prod_s      = a_lane_s * b_lane_s;
        prod_ext_s  = WIDTH'(prod_s);
        psum_next_s = psum_q + prod_ext_s;
    end

    // Requantisation of the incoming operands: wrap-add, shift, clamp, optional ReLU.
    always_comb begin
        sum_s = i_cfu_rs1 + i_cfu_rs2;
        shr_s = $signed(sum_s) >>> SHIFT;
        if (shr_s > QMAX) begin
            quant_s = QMAX;
        end else if (shr_s < QMIN) begin
            quant_s = QMIN;
        end else begin
            quant_s = shr_s;
        end
        if ((i_cfu_op == OP_QUANT_RELU) && sum_s[WIDTH-1]) begin
            quant_s = {WIDTH{1'b0}};
        end else begin
            quant_s = quant_s;
        end
    end

    // Counter read mux, sampled from the registered counters at request time.
    always_comb begin
        case (i_cfu_rs1[1:0])
            2'd0:    cnt_sel_s = cnt_cyc_q;
            2'd1:    cnt_sel_s = cnt_tot_q;
            2'd2:    cnt_sel_s = cnt_cpu_q;
            2'd3:    cnt_sel_s = cnt_ls_q;
            default: cnt_sel_s = {WIDTH{1'b0}};
        endcase
    end

    // Request FSM: latch, lane-serial MAC, one-cycle completion pulse.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        idx_d   = idx_q;
        psum_d  = psum_q;
        acc_d   = acc_q;
        ready_d = 1'b0;
        rd_d    = {WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (i_cfu_valid) begin
                    op_d  = i_cfu_op;
                    rs1_d = i_cfu_rs1;
                    rs2_d = i_cfu_rs2;
                    if ((i_cfu_op == OP_DOT) || (i_cfu_op == OP_DOTACC)) begin
                        state_d = ST_MAC;
                        idx_d   = {IDX_W{1'b0}};
                        psum_d  = {WIDTH{1'b0}};
                    end else begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        case (i_cfu_op)
                            OP_QUANT, OP_QUANT_RELU: rd_d = quant_s;
                            OP_ACC_RDCLR: begin
                                rd_d  = acc_q;
                                acc_d = {WIDTH{1'b0}};
                            end
                            OP_CNT_RD:  rd_d = cnt_sel_s;
                            OP_CNT_CLR: rd_d = {WIDTH{1'b0}};
                            OP_ACC_SET: begin
                                rd_d  = i_cfu_rs1;
                                acc_d = i_cfu_rs1;
                            end
                            default:    rd_d = {WIDTH{1'b0}};
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                psum_d = psum_next_s;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    idx_d   = {IDX_W{1'b0}};
                    if (op_q == OP_DOTACC) begin
                        acc_d = acc_q + psum_next_s;
                        rd_d  = acc_q + psum_next_s;
                    end else begin
                        rd_d  = psum_next_s;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Performance counters; a CNT_CLR completing this cycle overrides any increment.
    always_comb begin
        retire_s   = i_ibus_ack & i_rf_rreq;
        is_load_s  = (i_instruction[6:2] == 5'b00000);
        is_store_s = (i_instruction[6:2] == 5'b01000);
        is_mul_s   = (i_instruction[6:2] == 5'b01100) && (i_instruction[31:25] == 7'b0000001);
        cnt_clr_s  = (state_q == ST_DONE) && (op_q == OP_CNT_CLR);
        if (retire_s && is_load_s) begin
            cyc_inc_s = WIDTH'(LOAD_LAT);
        end else if (retire_s && is_store_s) begin
            cyc_inc_s = WIDTH'(STORE_LAT);
        end else begin
            cyc_inc_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (cnt_clr_s) begin
            cnt_cyc_d = {WIDTH{1'b0}};
            cnt_tot_d = {WIDTH{1'b0}};
            cnt_cpu_d = {WIDTH{1'b0}};
            cnt_ls_d  = {WIDTH{1'b0}};
        end else begin
            cnt_cyc_d = cnt_cyc_q + cyc_inc_s;
            cnt_tot_d = cnt_tot_q + {{(WIDTH-1){1'b0}}, retire_s};
            cnt_cpu_d = cnt_cpu_q + {{(WIDTH-1){1'b0}}, (retire_s & ~is_mul_s)};
            cnt_ls_d  = cnt_ls_q + {{(WIDTH-1){1'b0}}, (retire_s & (is_load_s | is_store_s))};
        end
    end

    // State, datapath and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            rs1_q     <= {WIDTH{1'b0}};
            rs2_q     <= {WIDTH{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            psum_q    <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            ready_q   <= 1'b0;
            rd_q      <= {WIDTH{1'b0}};
            cnt_cyc_q <= {WIDTH{1'b0}};
            cnt_tot_q <= {WIDTH{1'b0}};
            cnt_cpu_q <= {WIDTH{1'b0}};
            cnt_ls_q  <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            idx_q     <= idx_d;
            psum_q    <= psum_d;
            acc_q     <= acc_d;
            ready_q   <= ready_d;
            rd_q      <= rd_d;
            cnt_cyc_q <= cnt_cyc_d;
            cnt_tot_q <= cnt_tot_d;
            cnt_cpu_q <= cnt_cpu_d;
            cnt_ls_q  <= cnt_ls_d;
        end
    end

    assign o_cfu_ready = ready_q;
    assign o_cfu_rd    = rd_q;

endmodule

// File: tb/tb_cfu_packed_mac.sv
// Directed bench for cfu_packed_mac: a LANE_W=4 and a LANE_W=8 instance share
// operands and retire inputs; each has its own request strobe.
module tb_cfu_packed_mac;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] rs1 = 32'h0, rs2 = 32'h0, instr = 32'h0;
    logic [2:0]  cfu_op = 3'b000;
    logic        valid4 = 1'b0, valid8 = 1'b0, ack = 1'b0, rreq = 1'b0;
    logic        rdy4, rdy8;
    logic [31:0] rd4, rd8;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] I_LOAD  = 32'h00002003;
    localparam logic [31:0] I_STORE = 32'h00002023;
    localparam logic [31:0] I_MUL   = 32'h02000033;
    localparam logic [31:0] I_ADD   = 32'h00000033;

    always #5 i_clk = ~i_clk;

    cfu_packed_mac #(.LANE_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfu_rs1(rs1), .i_cfu_rs2(rs2),
        .i_cfu_op(cfu_op), .i_cfu_valid(valid4), .i_ibus_ack(ack), .i_rf_rreq(rreq),
        .i_instruction(instr), .o_cfu_ready(rdy4), .o_cfu_rd(rd4)
    );

    cfu_packed_mac #(.LANE_W(8)) dut8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfu_rs1(rs1), .i_cfu_rs2(rs2),
        .i_cfu_op(cfu_op), .i_cfu_valid(valid8), .i_ibus_ack(ack), .i_rf_rreq(rreq),
        .i_instruction(instr), .o_cfu_ready(rdy8), .o_cfu_rd(rd8)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          sel;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request from an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit sel, input bit done_strobe,
                         output logic [31:0] rd, output int lat);
        cfu_op = op;
        rs1    = a;
        rs2    = b;
        if (sel) valid8 = 1'b1;
        else     valid4 = 1'b1;
        lat = -1;
        rd  = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge i_clk); #1;
            if ((sel ? rdy8 : rdy4) === 1'b1) begin
                lat = c;
                rd  = sel ? rd8 : rd4;
                break;
            end
        end
        valid4 = 1'b0;
        valid8 = 1'b0;
        checks++;
        if (lat < 0) begin
            fails++;
            $display("FAIL ready_timeout: op=%0d got no ready within 40 cycles, expected ready", op);
        end
        if (done_strobe) begin
            ack = 1'b1; rreq = 1'b1; instr = I_ADD;
        end
        @(posedge i_clk); #1;
        ack = 1'b0; rreq = 1'b0; instr = 32'h0;
        check("ready_pulse_drop", {31'h0, (sel ? rdy8 : rdy4)}, 32'h0);
        check("rd_zero_after_ready", sel ? rd8 : rd4, 32'h0);
    endtask

    // One retire strobe followed by one idle cycle.
    task automatic retire(input logic [31:0] ins);
        ack = 1'b1; rreq = 1'b1; instr = ins;
        @(posedge i_clk); #1;
        ack = 1'b0; rreq = 1'b0; instr = 32'h0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;

        vecs[0]  = '{"dot_ones_twos",   3'b000, 32'h11111111, 32'h22222222, 1'b0, 32'h00000010, 9};
        vecs[1]  = '{"dot_neg",         3'b000, 32'hFFFFFFFF, 32'h77777777, 1'b0, 32'hFFFFFFC8, 9};
        vecs[2]  = '{"acc_set",         3'b111, 32'h00000064, 32'h00000000, 1'b0, 32'h00000064, 1};
        vecs[3]  = '{"dotacc_1",        3'b001, 32'h11111111, 32'h22222222, 1'b0, 32'h00000074, 9};
        vecs[4]  = '{"dotacc_2",        3'b001, 32'h11111111, 32'h22222222, 1'b0, 32'h00000084, 9};
        vecs[5]  = '{"acc_rdclr_1",     3'b100, 32'h00000000, 32'h00000000, 1'b0, 32'h00000084, 1};
        vecs[6]  = '{"acc_rdclr_2",     3'b100, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1};
        vecs[7]  = '{"quant_128",       3'b010, 32'd100,      32'd28,       1'b0, 32'h00000004, 1};
        vecs[8]  = '{"quant_clamp_hi",  3'b010, 32'd1000,     32'd0,        1'b0, 32'h00000007, 1};
        vecs[9]  = '{"quant_clamp_lo",  3'b010, 32'hFFFFFC18, 32'd0,        1'b0, 32'hFFFFFFF8, 1};
        vecs[10] = '{"quant_relu_neg",  3'b011, 32'hFFFFFC18, 32'd0,        1'b0, 32'h00000000, 1};
        vecs[11] = '{"quant_relu_pos",  3'b011, 32'd100,      32'd28,       1'b0, 32'h00000004, 1};
        vecs[12] = '{"quant_lane8",     3'b010, 32'd1000,     32'd0,        1'b1, 32'h0000001F, 1};
        vecs[13] = '{"dot_lane8",       3'b000, 32'h80808080, 32'h7F7F7F7F, 1'b1, 32'hFFFF0200, 5};

        repeat (2) @(posedge i_clk);
        #1;
        check("reset_ready", {31'h0, rdy4}, 32'h0);
        check("reset_rd", rd4, 32'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // LANE_W=4 vectors first; the LANE_W=8 instance is only used at the end.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel, 1'b0, rd, lat);
            check({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
            check_int({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
        end

        // Clear with a retire strobe in the DONE cycle: clear must win.
        issue(3'b110, 32'h0, 32'h0, 1'b0, 1'b1, rd, lat);
        check("cnt_clr_rd", rd, 32'h0);
        issue(3'b101, 32'd1, 32'h0, 1'b0, 1'b0, rd, lat);
        check("clr_wins_total", rd, 32'h0);
        issue(3'b101, 32'd2, 32'h0, 1'b0, 1'b0, rd, lat);
        check("clr_wins_cpu", rd, 32'h0);

        // Clean clear, four retires each followed by one idle cycle.
        issue(3'b110, 32'h0, 32'h0, 1'b0, 1'b0, rd, lat);
        retire(I_LOAD);
        retire(I_STORE);
        retire(I_MUL);
        retire(I_ADD);
        issue(3'b101, 32'd0, 32'h0, 1'b0, 1'b0, rd, lat);
        check("cnt_cycles", rd, 32'd99);
        issue(3'b101, 32'd1, 32'h0, 1'b0, 1'b0, rd, lat);
        check("cnt_total", rd, 32'd4);
        issue(3'b101, 32'd2, 32'h0, 1'b0, 1'b0, rd, lat);
        check("cnt_cpu", rd, 32'd3);
        issue(3'b101, 32'd3, 32'h0, 1'b0, 1'b0, rd, lat);
        check("cnt_ldst", rd, 32'd2);

        // Reset in MAC cycle 4 of a DOT with a non-zero accumulator.
        issue(3'b111, 32'h00000055, 32'h0, 1'b0, 1'b0, rd, lat);
        check("acc_set_pre_reset", rd, 32'h00000055);
        cfu_op = 3'b000; rs1 = 32'h11111111; rs2 = 32'h22222222; valid4 = 1'b1;
        repeat (4) begin
            @(posedge i_clk); #1;
        end
        i_rst_n = 1'b0;
        valid4  = 1'b0;
        #1;
        check("midmac_rst_ready", {31'h0, rdy4}, 32'h0);
        check("midmac_rst_rd", rd4, 32'h0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        issue(3'b000, 32'h11111111, 32'h22222222, 1'b0, 1'b0, rd, lat);
        check("post_rst_dot_rd", rd, 32'h00000010);
        check_int("post_rst_dot_lat", lat, 9);
        issue(3'b100, 32'h0, 32'h0, 1'b0, 1'b0, rd, lat);
        check("post_rst_acc", rd, 32'h0);
        issue(3'b101, 32'd1, 32'h0, 1'b0, 1'b0, rd, lat);
        check("post_rst_total", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
